// File: rtl/image_frame_loader.sv
// ============================================================================
// image_frame_loader
//   Assembles a serial 32x32 1-bit pixel stream into a frame, launches the
//   recogniser on it and returns its digit. Optional TPU_TIMEOUT_EN adds a
//   16-bit watchdog on the recogniser run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module image_frame_loader (
   input  logic          clk,
   input  logic          iRst_n,
   input  logic          pix_valid,
   input  logic          pix_data,
   input  logic          pix_sof,
   output logic          pix_ready,
   output logic [1023:0] image_out,
   output logic          tpu_ena,
   output logic          tpu_rstn,
   input  logic          tpu_done,
   input  logic [3:0]    tpu_num,
   output logic [3:0]    result,
   output logic          result_valid,
   output logic          err
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam logic [9:0] c_LAST_PIX = 10'd1023;

   state_t     r_state;
   logic [9:0] r_n;
   logic       w_accept;

   assign w_accept = (r_state == LOAD) && pix_valid && pix_ready;

`ifdef TPU_TIMEOUT_EN
   // The watchdog fires on the edge where the counter would reach 65535.
   localparam logic [15:0] c_TMO_LAST = 16'hFFFE;
   logic [15:0] r_tmo;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!iRst_n) begin
         r_state      <= LOAD;
         r_n          <= 10'd0;
         pix_ready    <= 1'b0;
         image_out    <= '0;
         tpu_ena      <= 1'b0;
         tpu_rstn     <= 1'b1;
         result       <= 4'd0;
         result_valid <= 1'b0;
`ifdef TPU_TIMEOUT_EN
         err          <= 1'b0;
         r_tmo        <= 16'd0;
`endif
      end else begin
         result_valid <= 1'b0;
`ifdef TPU_TIMEOUT_EN
         err          <= 1'b0;
`endif
         case (r_state)
            LOAD: begin
               pix_ready <= 1'b1;
               if (w_accept) begin
                  if (pix_sof) begin
                     image_out[0] <= pix_data;
                     r_n          <= 10'd1;
                  end else begin
                     image_out[r_n] <= pix_data;
                     if (r_n == c_LAST_PIX) begin
                        r_n       <= 10'd0;
                        pix_ready <= 1'b0;
                        tpu_ena   <= 1'b1;
                        tpu_rstn  <= 1'b0;
                        r_state   <= START;
                     end else begin
                        r_n <= r_n + 10'd1;
                     end
                  end
               end
            end
            START: begin
               tpu_rstn <= 1'b1;
               r_state  <= RUN;
`ifdef TPU_TIMEOUT_EN
               r_tmo    <= 16'd0;
`endif
            end
            RUN: begin
               if (tpu_done) begin
                  result       <= tpu_num;
                  result_valid <= 1'b1;
                  tpu_ena      <= 1'b0;
                  pix_ready    <= 1'b1;
                  r_state      <= LOAD;
               end
`ifdef TPU_TIMEOUT_EN
               else if (r_tmo == c_TMO_LAST) begin
                  r_tmo        <= 16'hFFFF;
                  result       <= 4'hF;
                  result_valid <= 1'b1;
                  err          <= 1'b1;
                  tpu_ena      <= 1'b0;
                  pix_ready    <= 1'b1;
                  r_state      <= LOAD;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
`endif
            end
            default: r_state <= LOAD;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_image_frame_loader.sv
// ============================================================================
// tb_image_frame_loader
//   Table-driven frame/result checks plus reset-in-RUN and timeout sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_image_frame_loader;

   logic          clk = 1'b0;
   logic          iRst_n;
   logic          pix_valid, pix_data, pix_sof;
   logic          pix_ready;
   logic [1023:0] image_out;
   logic          tpu_ena, tpu_rstn, tpu_done;
   logic [3:0]    tpu_num;
   logic [3:0]    result;
   logic          result_valid, err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_stall  = 0;

   image_frame_loader dut (
      .clk(clk), .iRst_n(iRst_n), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_sof(pix_sof), .pix_ready(pix_ready), .image_out(image_out),
      .tpu_ena(tpu_ena), .tpu_rstn(tpu_rstn), .tpu_done(tpu_done),
      .tpu_num(tpu_num), .result(result), .result_valid(result_valid), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;    // pixel pattern
      int         gap;     // 1: sparse valid with gaps
      int         sof_at;  // -1 no sof, 0 sof on first pixel, >0 resync point
      int         lat;     // RUN cycles before tpu_done
      logic [3:0] num;     // digit returned, also expected result
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_img(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic px(input int kind, input int n);
      case (kind)
         0:       return (n / 32) == (n % 32);
         1:       return 1'((n % 2) ^ ((n / 32) % 2));
         default: return (n % 5) == 1;
      endcase
   endfunction

   function automatic logic [1023:0] img(input int kind);
      logic [1023:0] v;
      for (int i = 0; i < 1024; i++) v[i] = px(kind, i);
      return v;
   endfunction

   task automatic idle(input int cycles);
      pix_valid = 1'b0;
      pix_data  = 1'b1;
      pix_sof   = 1'b1;
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic send_px(input logic d, input logic s);
      int w;
      w = 0;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = s;
      while (!pix_ready && w < 8) begin
         step();
         w++;
      end
      if (!pix_ready) n_stall++;
      step();
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic feed_frame(input vec_t v);
      for (int p = 0; p < v.sof_at; p++) begin
         if (v.gap != 0 && p > 0) idle((p % 7 == 3) ? 3 : 1);
         send_px(~px(v.kind, p), 1'b0);
      end
      for (int m = 0; m < 1024; m++) begin
         if (v.gap != 0 && (m > 0 || v.sof_at > 0)) idle((m % 7 == 3) ? 3 : 1);
         send_px(px(v.kind, m), (m == 0) && (v.sof_at >= 0));
      end
   endtask

   // Feeds a frame, plays the recogniser, checks the START/RUN/result cycle.
   task automatic run_frame(input vec_t v);
      logic [1023:0] exp_img;
      exp_img = img(v.kind);
      n_stall = 0;
      feed_frame(v);
      chk("no_stall", n_stall, 0);
      chk("start_ctl", {pix_ready, tpu_ena, tpu_rstn, result_valid}, 4'b0100);
      chk_img("frame_img", image_out, exp_img);
      if (v.kind == 0) begin
         chk("diag_bit33", image_out[33], 1);
         chk("diag_bit34", image_out[34], 0);
      end
      pix_valid = 1'b1;
      pix_sof   = 1'b1;
      pix_data  = 1'b1;
      tpu_num   = 4'd13;
      tpu_done  = (v.lat > 1);
      step();
      for (int k = 1; k <= v.lat; k++) begin
         chk("run_ctl", {pix_ready, tpu_ena, tpu_rstn, result_valid}, 4'b0110);
         tpu_done = (k == v.lat);
         tpu_num  = (k == v.lat) ? v.num : 4'd13;
         if (k == v.lat) pix_valid = 1'b0;
         step();
      end
      chk_img("run_img_hold", image_out, exp_img);
      chk("res_val", result, v.num);
      chk("res_ctl", {pix_ready, tpu_ena, result_valid, err}, 4'b1010);
      step();
      chk("res_pulse_end", {result_valid, pix_ready}, 2'b01);
      chk("res_hold", result, v.num);
      tpu_done = 1'b0;
      tpu_num  = 4'd0;
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{kind: 0, gap: 0, sof_at: -1,  lat: 50, num: 4'd7};
      vecs[1] = '{kind: 1, gap: 1, sof_at: 0,   lat: 5,  num: 4'd3};
      vecs[2] = '{kind: 0, gap: 1, sof_at: -1,  lat: 1,  num: 4'd9};
      vecs[3] = '{kind: 2, gap: 0, sof_at: 500, lat: 3,  num: 4'd0};

      iRst_n = 1'b0; pix_valid = 1'b0; pix_data = 1'b0; pix_sof = 1'b0;
      tpu_done = 1'b0; tpu_num = 4'd0;
      step(); step();
      chk("rst_ctl", {pix_ready, tpu_ena, tpu_rstn, result_valid, err}, 5'b00100);
      chk("rst_res", result, 0);
      chk_img("rst_img", image_out, '0);
      iRst_n = 1'b1;
      step();
      chk("rst_rel_ready", pix_ready, 1);

      for (int i = 0; i < 4; i++) run_frame(vecs[i]);

      // Reset while the recogniser is running aborts the frame.
      feed_frame(vecs[0]);
      step(); step();
      chk("pre_rst_run", {tpu_ena, tpu_rstn}, 2'b11);
      iRst_n   = 1'b0;
      tpu_done = 1'b1;
      tpu_num  = 4'd5;
      step();
      chk("midrst_ctl", {pix_ready, tpu_ena, tpu_rstn, result_valid}, 4'b0010);
      chk("midrst_res", result, 0);
      chk_img("midrst_img", image_out, '0);
      iRst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("done_in_load", {result_valid, tpu_ena, pix_ready}, 3'b001);
      end
      tpu_done = 1'b0;
      run_frame('{kind: 1, gap: 0, sof_at: -1, lat: 4, num: 4'd6});

`ifdef TPU_TIMEOUT_EN
      begin
         int cyc;
         feed_frame(vecs[0]);
         step();
         cyc = 0;
         while (!result_valid && cyc < 70000) begin
            step();
            cyc++;
         end
         chk("tmo_latency", cyc, 65535);
         chk("tmo_res", result, 4'hF);
         chk("tmo_ctl", {err, result_valid, tpu_ena, pix_ready}, 4'b1101);
         step();
         chk("tmo_pulse_end", {err, result_valid}, 2'b00);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
